// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared widths and NOP payloads for the MiniMIPS32 stage registers.
package pipe_stage_reg_pkg;
  localparam int OCC_W = 2;
  localparam int IFID_W = 64;
  localparam int IDEXE_W = 128;
  localparam int EXEMEM_W = 96;
  localparam int MEMWB_W = 72;
  // SLL $0,$0,0 encodes as all zeros; write-enable bits in each payload are zero too
  localparam logic [31:0] SLL_NOP = 32'h0000_0000;
  localparam logic [IFID_W-1:0] IFID_NOP = {{(IFID_W-32){1'b0}}, SLL_NOP};
  localparam logic [IDEXE_W-1:0] IDEXE_NOP = '0;
  localparam logic [EXEMEM_W-1:0] EXEMEM_NOP = '0;
  localparam logic [MEMWB_W-1:0] MEMWB_NOP = '0;
  typedef enum logic [OCC_W-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE = 2'd1,
    OCC_FULL = 2'd2
  } occ_e;
endpackage

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: W-bit data register with a reset-only valid flop and load/clear enables.
module pipe_slot #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ld_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic         vld_o,
  output logic [W-1:0] q_o
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  always_comb begin
    valid_d = clr_i ? 1'b0 : ld_i ? 1'b1 : valid_q;
    data_d = ld_i ? d_i : data_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) valid_q <= 1'b0;
    else valid_q <= valid_d;
  end
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end
  assign vld_o = valid_q;
  assign q_o = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush and optional two-entry skid buffer.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int          W         = 128,
  parameter logic [W-1:0] NOP_VALUE = '0,
  parameter bit          SKID      = 1'b1
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [OCC_W-1:0] occupancy
);
  logic         main_v, skid_v, in_fire, out_fire, main_ld, main_clr;
  logic [W-1:0] main_data, skid_data, main_din;
  assign in_fire = in_valid & in_ready;
  assign out_fire = main_v & out_ready;
  // skid is always the younger entry, so it refills main when main drains
  assign main_din = skid_v ? skid_data : in_data;
  assign main_ld = !flush & (skid_v ? out_fire : in_fire & (!main_v | out_fire));
  assign main_clr = flush | (out_fire & !skid_v & !in_fire);
  pipe_slot #(.W(W)) u_main (
    .clk_i(cpu_clk_50M),
    .rst_i(cpu_rst),
    .ld_i (main_ld),
    .clr_i(main_clr),
    .d_i  (main_din),
    .vld_o(main_v),
    .q_o  (main_data)
  );
  generate
    if (SKID) begin : g_skid
      logic skid_ld, skid_clr;
      assign skid_ld = !flush & main_v & !skid_v & in_fire & !out_fire;
      assign skid_clr = flush | (skid_v & out_fire);
      pipe_slot #(.W(W)) u_skid (
        .clk_i(cpu_clk_50M),
        .rst_i(cpu_rst),
        .ld_i (skid_ld),
        .clr_i(skid_clr),
        .d_i  (in_data),
        .vld_o(skid_v),
        .q_o  (skid_data)
      );
      assign in_ready = !skid_v;
    end else begin : g_noskid
      assign skid_v = 1'b0;
      assign skid_data = '0;
      assign in_ready = !main_v | out_ready;
    end
  endgenerate
  assign out_valid = main_v;
  assign out_data = main_v ? main_data : NOP_VALUE;
  assign occupancy = OCC_W'(main_v) + OCC_W'(skid_v);
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: queue-model checking of SKID=1 and SKID=0 instances under shared stimulus.
module tb_pipe_stage_reg;
  localparam logic [31:0] NOP = 32'hFFFF_0000;
  logic        clk = 1'b0, rst, fl, iv, ordy;
  logic [31:0] id;
  logic        ir_a, ov_a, ir_b, ov_b;
  logic [31:0] od_a, od_b;
  logic [1:0]  oc_a, oc_b;
  logic [31:0] qa[$], qb[$];
  int          n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  pipe_stage_reg #(.W(32), .NOP_VALUE(NOP), .SKID(1'b1)) dut_a (
    .cpu_clk_50M(clk), .cpu_rst(rst), .flush(fl), .in_valid(iv), .in_ready(ir_a),
    .in_data(id), .out_valid(ov_a), .out_ready(ordy), .out_data(od_a), .occupancy(oc_a)
  );
  pipe_stage_reg #(.W(32), .NOP_VALUE(NOP), .SKID(1'b0)) dut_b (
    .cpu_clk_50M(clk), .cpu_rst(rst), .flush(fl), .in_valid(iv), .in_ready(ir_b),
    .in_data(id), .out_valid(ov_b), .out_ready(ordy), .out_data(od_b), .occupancy(oc_b)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask
  // model: a FIFO of held entries; capacity 2 with registered ready, or 1 with pass-through ready
  initial forever begin
    @(negedge clk);
    chk("a_valid", 32'(ov_a), 32'(qa.size() != 0));
    chk("a_data", od_a, qa.size() != 0 ? qa[0] : NOP);
    chk("a_occ", 32'(oc_a), 32'(qa.size()));
    chk("a_ready", 32'(ir_a), 32'(qa.size() < 2));
    chk("b_valid", 32'(ov_b), 32'(qb.size() != 0));
    chk("b_data", od_b, qb.size() != 0 ? qb[0] : NOP);
    chk("b_occ", 32'(oc_b), 32'(qb.size()));
    chk("b_ready", 32'(ir_b), 32'(qb.size() == 0 || ordy));
  end
  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
    bit fa_in, fa_out, fb_in, fb_out;
    iv = v; id = d; ordy = r; fl = f;
    @(posedge clk); #1;
    if (!rst) begin
      fa_in = iv && qa.size() < 2;
      fa_out = qa.size() != 0 && ordy;
      fb_in = iv && (qb.size() == 0 || ordy);
      fb_out = qb.size() != 0 && ordy;
      if (fl) begin
        qa.delete();
        qb.delete();
      end else begin
        if (fa_out) void'(qa.pop_front());
        if (fa_in) qa.push_back(id);
        if (fb_out) void'(qb.pop_front());
        if (fb_in) qb.push_back(id);
      end
    end
  endtask
  initial begin
    rst = 1'b1; iv = 1'b1; id = 32'hDEAD_BEEF; ordy = 1'b1; fl = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_data", od_a, NOP);
    chk("rst_a_ready", 32'(ir_a), 32'd1);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 32'(i), 1'b1, 1'b0);
      chk("stream_a_data", od_a, 32'(i));
      chk("stream_a_occ", 32'(oc_a), 32'd1);
    end
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b0);
    chk("stall_a_occ", 32'(oc_a), 32'd2);
    chk("stall_a_ready", 32'(ir_a), 32'd0);
    chk("stall_a_head", od_a, 32'hA);
    chk("stall_b_ready", 32'(ir_b), 32'd0);
    step(1'b1, 32'hC, 1'b1, 1'b0);
    chk("drain_a_B", od_a, 32'hB);
    step(1'b1, 32'hC, 1'b1, 1'b0);
    chk("drain_a_C", od_a, 32'hC);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("drain_a_empty", 32'(ov_a), 32'd0);
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    chk("full_a_occ", 32'(oc_a), 32'd2);
    step(1'b1, 32'hC, 1'b0, 1'b1);
    chk("flush_a_occ", 32'(oc_a), 32'd0);
    chk("flush_a_data", od_a, NOP);
    chk("flush_b_occ", 32'(oc_b), 32'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b1, 32'h5, 1'b1, 1'b0);
    step(1'b1, 32'h6, 1'b1, 1'b1);
    chk("flush_fire_a", 32'(ov_a), 32'd0);
    step(1'b1, 32'h11, 1'b0, 1'b0);
    chk("noskid_b_ready", 32'(ir_b), 32'd0);
    step(1'b1, 32'h22, 1'b1, 1'b0);
    chk("noskid_b_data", od_b, 32'h22);
    chk("noskid_b_occ", 32'(oc_b), 32'd1);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b1, 32'h31, 1'b0, 1'b0);
    step(1'b1, 32'h32, 1'b0, 1'b0);
    chk("pre_rst_a_occ", 32'(oc_a), 32'd2);
    #2;
    rst = 1'b1;
    qa.delete();
    qb.delete();
    #1;
    chk("arst_a_valid", 32'(ov_a), 32'd0);
    chk("arst_a_occ", 32'(oc_a), 32'd0);
    chk("arst_a_data", od_a, NOP);
    chk("arst_b_valid", 32'(ov_b), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, 32'h41, 1'b1, 1'b0);
    chk("post_rst_a_data", od_a, 32'h41);
    chk("post_rst_a_valid", 32'(ov_a), 32'd1);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
